// File: rtl/wb_commit_logger.sv
// Writeback commit logger: buffers retired-instruction records in a FIFO for the trace consumer,
// detects the end-of-program self-loop, then drains and raises done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | retirements are captured (or dropped when full)
// S_DRAIN | halt loop seen; retirements ignored, waiting for FIFO empty
// S_DONE  | program ended and FIFO drained; held until reset
module wb_commit_logger #(
  parameter int DEPTH       = 16,
  parameter int HALT_REPEAT = 4,
  parameter int SEQ_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_valid,
  input  logic [31:0]                w_pc,
  input  logic                       w_enable,
  input  logic [4:0]                 w_destination,
  input  logic [31:0]                w_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic                       out_we,
  output logic [4:0]                 out_rd,
  output logic [31:0]                out_data,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [SEQ_W-1:0]           drop_count,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic             we;
    logic [4:0]       rd;
    logic [31:0]      data;
    logic [SEQ_W-1:0] seq;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             wrec;
  rec_t             head;
  state_t           state, state_next;
  logic [AW-1:0]    wptr, rptr;
  logic [SEQ_W-1:0] seq;
  logic [RW-1:0]    rep, rep_next;
  logic [31:0]      last_pc;
  logic             full, pop, push_req, push, drop, halt;

  always_comb begin
    pop      = out_valid && out_ready;
    full     = (level == LW'(DEPTH));
    push_req = w_valid && (state == S_RUN);
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    // rep == 0 means nothing has retired since reset
    if (rep != '0 && w_pc == last_pc)
      rep_next = (rep == RW'(HALT_REPEAT)) ? rep : rep + RW'(1);
    else
      rep_next = RW'(1);
    halt = push_req && (rep_next == RW'(HALT_REPEAT));
    wrec.pc   = w_pc;
    wrec.we   = w_enable;
    wrec.rd   = w_enable ? w_destination : 5'd0;
    wrec.data = w_enable ? w_data : 32'd0;
    wrec.seq  = seq;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (halt) state_next = S_DRAIN;
      S_DRAIN: if (level == '0) state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      seq        <= '0;
      rep        <= '0;
      last_pc    <= '0;
    end else begin
      if (w_valid) begin
        rep     <= rep_next;
        last_pc <= w_pc;
      end
      if (push) begin
        wptr <= wptr + AW'(1);
        seq  <= seq + SEQ_W'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (!(&drop_count)) drop_count <= drop_count + SEQ_W'(1);
      end
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wrec;
  end

  assign head      = mem[rptr];
  assign out_valid = (level != '0);
  assign out_pc    = head.pc;
  assign out_we    = head.we;
  assign out_rd    = head.rd;
  assign out_data  = head.data;
  assign out_seq   = head.seq;
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_wb_commit_logger.sv
// Self-checking bench for wb_commit_logger: scoreboard of expected records plus directed
// checks of occupancy, overflow, halt/drain and asynchronous reset.
module tb_wb_commit_logger;

  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             w_valid, w_enable, out_ready;
  logic [31:0]      w_pc, w_data;
  logic [4:0]       w_destination;
  logic             out_valid, out_we, overflow, done;
  logic [31:0]      out_pc, out_data;
  logic [4:0]       out_rd;
  logic [SEQ_W-1:0] out_seq, drop_count;
  logic [4:0]       level;

  typedef struct {
    logic [31:0]      pc;
    logic             we;
    logic [4:0]       rd;
    logic [31:0]      data;
    logic [SEQ_W-1:0] seq;
  } exp_t;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [SEQ_W-1:0] exp_seq;

  wb_commit_logger #(.DEPTH(DEPTH), .HALT_REPEAT(4), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_pc(w_pc), .w_enable(w_enable),
    .w_destination(w_destination), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_we(out_we), .out_rd(out_rd),
    .out_data(out_data), .out_seq(out_seq), .level(level), .overflow(overflow),
    .drop_count(drop_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic en, input logic [4:0] rd,
                        input logic [31:0] d, input bit acc);
    exp_t e;
    w_valid = 1'b1; w_pc = pc; w_enable = en; w_destination = rd; w_data = d;
    if (acc) begin
      e.pc = pc; e.we = en; e.rd = en ? rd : 5'd0; e.data = en ? d : 32'd0; e.seq = exp_seq;
      sb.push_back(e);
      exp_seq++;
    end
    tick();
    w_valid = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    exp_seq = '0;
  endtask

  // Consumer side: a record on the head with out_ready high is taken at the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("sb_unexpected_pop", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("rec_pc", out_pc, e.pc);
        check_val("rec_we", out_we, e.we);
        check_val("rec_rd", out_rd, e.rd);
        check_val("rec_data", out_data, e.data);
        check_val("rec_seq", out_seq, e.seq);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; w_valid = 1'b0; w_enable = 1'b0; w_pc = '0; w_data = '0;
    w_destination = '0; out_ready = 1'b0; exp_seq = '0;
    #1;
    check_val("rst_level", level, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_drops", drop_count, 0);
    check_val("rst_done", done, 0);
    tick(); tick();
    reset = 1'b0;

    // streaming with consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      retire(32'h0100_0000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(100 + i), 1'b1);
      check_val("stream_valid", out_valid, 1);
      check_val("stream_seq", out_seq, i);
      check_val("stream_level_le1", level <= 5'd1, 1);
    end
    tick();
    check_val("stream_empty", level, 0);

    // write-enable masking
    retire(32'h0100_0020, 1'b0, 5'd7, 32'h55, 1'b1);
    check_val("mask_we", out_we, 0);
    check_val("mask_rd", out_rd, 0);
    check_val("mask_data", out_data, 0);
    retire(32'h0100_0024, 1'b1, 5'd7, 32'h55, 1'b1);
    check_val("unmask_rd", out_rd, 7);
    check_val("unmask_data", out_data, 32'h55);
    tick();
    check_val("mask_sb_empty", sb.size(), 0);

    // overflow
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++)
      retire(32'h0200_0000 + 32'(4 * i), 1'b1, 5'(i), 32'(i * 3), i < 16);
    check_val("ovf_level", level, 16);
    check_val("ovf_flag", overflow, 1);
    check_val("ovf_drops", drop_count, 2);

    // full: push and pop in the same cycle
    out_ready = 1'b1;
    retire(32'h0200_1000, 1'b1, 5'd3, 32'habc, 1'b1);
    check_val("fullpp_level", level, 16);
    check_val("fullpp_drops", drop_count, 2);
    for (int k = 0; k < 40 && level != 0; k++) tick();
    check_val("ovf_drained", level, 0);
    check_val("ovf_sb_empty", sb.size(), 0);

    // halt detection and drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) retire(32'h0100_0010, 1'b1, 5'd1, 32'(i), 1'b1);
    check_val("halt_level4", level, 4);
    retire(32'h0100_0010, 1'b1, 5'd1, 32'd9, 1'b0);
    check_val("halt_ignored", level, 4);
    check_val("halt_nodrop", drop_count, 2);
    check_val("halt_not_done", done, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && level != 0; k++) tick();
    check_val("halt_drained", level, 0);
    check_val("halt_done_late", done, 0);
    tick();
    check_val("halt_done", done, 1);
    retire(32'h0100_0050, 1'b1, 5'd2, 32'd3, 1'b0);
    check_val("done_ignored", level, 0);
    check_val("done_hold", done, 1);
    check_val("halt_sb_empty", sb.size(), 0);

    // asynchronous reset in the middle of a drain
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) retire(32'h0300_0000, 1'b1, 5'd5, 32'(i), 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("mid_level3", level, 3);
    check_val("mid_not_done", done, 0);
    #2 reset = 1'b1;
    #1;
    check_val("arst_level", level, 0);
    check_val("arst_valid", out_valid, 0);
    check_val("arst_done", done, 0);
    sb.delete();
    exp_seq = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    retire(32'h0300_0100, 1'b1, 5'd4, 32'h77, 1'b1);
    check_val("post_rst_valid", out_valid, 1);
    check_val("post_rst_seq", out_seq, 0);
    tick();
    check_val("post_rst_empty", level, 0);
    check_val("post_rst_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
